// File: rtl/serial_addsub_unit.sv
`default_nettype none
// ============================================================================
// Module   : serial_addsub_unit
// Brief    : Digit-serial add/subtract engine with valid/ready handshakes.
// Revision : 1.0
// ============================================================================
module serial_addsub_unit #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  input  logic             cin,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             busy
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_op;
  logic             r_carry;
  logic             r_amsb;
  logic             r_bmsb;
  logic [CW-1:0]    r_cnt;

  logic [DIGIT:0]   w_sum;
  logic [WIDTH-1:0] w_res_next;
  logic [WIDTH-1:0] w_b_in;
  logic             w_accept;
  logic             w_last;

  assign in_ready = (r_state == S_IDLE) | ((r_state == S_DONE) & out_ready);
  assign w_accept = in_valid & in_ready;
  assign w_b_in   = op ? ~b : b;
  assign w_last   = (r_cnt == CW'(N - 1));
  assign w_sum    = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]}
                  + {{DIGIT{1'b0}}, r_carry};

  // Result fills from the top so the LSB digit lands at bit 0 after N shifts.
  generate
    if (DIGIT == WIDTH) begin : g_single
      assign w_res_next = w_sum[DIGIT-1:0];
    end else begin : g_multi
      assign w_res_next = {w_sum[DIGIT-1:0], r_res[WIDTH-1:DIGIT]};
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_res     <= '0;
      r_op      <= 1'b0;
      r_carry   <= 1'b0;
      r_amsb    <= 1'b0;
      r_bmsb    <= 1'b0;
      r_cnt     <= '0;
      result    <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (w_accept) begin
      r_state   <= S_RUN;
      r_a       <= a;
      r_b       <= w_b_in;
      r_op      <= op;
      r_carry   <= op ? ~cin : cin;
      r_amsb    <= a[WIDTH-1];
      r_bmsb    <= w_b_in[WIDTH-1];
      r_cnt     <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: ;
        S_RUN: begin
          if (abort) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end else begin
            r_res   <= w_res_next;
            r_a     <= r_a >> DIGIT;
            r_b     <= r_b >> DIGIT;
            r_carry <= w_sum[DIGIT];
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
              result    <= w_res_next;
              cout      <= r_op ? ~w_sum[DIGIT] : w_sum[DIGIT];
              ovf       <= (r_amsb == r_bmsb) & (w_res_next[WIDTH-1] != r_amsb);
              zero      <= (w_res_next == '0);
              out_valid <= 1'b1;
              busy      <= 1'b0;
              r_state   <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_addsub_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_addsub_unit
// Brief    : Scoreboard bench for serial_addsub_unit at DIGIT=1 and DIGIT=4.
// Revision : 1.0
// ============================================================================
module tb_serial_addsub_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         iv1 = 1'b0, iv4 = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         op = 1'b0, cin = 1'b0, abort = 1'b0, out_ready = 1'b1;
  logic         sel = 1'b0;

  logic         ir1, ov1, co1, vf1, z1, bz1;
  logic         ir4, ov4, co4, vf4, z4, bz4;
  logic [W-1:0] res1, res4;

  logic         m_ir, m_ov, m_co, m_vf, m_z, m_bz;
  logic [W-1:0] m_res;

  assign m_ir  = sel ? ir4  : ir1;
  assign m_ov  = sel ? ov4  : ov1;
  assign m_co  = sel ? co4  : co1;
  assign m_vf  = sel ? vf4  : vf1;
  assign m_z   = sel ? z4   : z1;
  assign m_bz  = sel ? bz4  : bz1;
  assign m_res = sel ? res4 : res1;

  serial_addsub_unit #(.WIDTH(W), .DIGIT(1)) u_d1 (
    .clk(clk), .reset(reset), .in_valid(iv1), .in_ready(ir1), .a(a), .b(b),
    .op(op), .cin(cin), .abort(abort), .out_valid(ov1), .out_ready(out_ready),
    .result(res1), .cout(co1), .ovf(vf1), .zero(z1), .busy(bz1)
  );

  serial_addsub_unit #(.WIDTH(W), .DIGIT(4)) u_d4 (
    .clk(clk), .reset(reset), .in_valid(iv4), .in_ready(ir4), .a(a), .b(b),
    .op(op), .cin(cin), .abort(abort), .out_valid(ov4), .out_ready(out_ready),
    .result(res4), .cout(co4), .ovf(vf4), .zero(z4), .busy(bz4)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         v;
    logic         z;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic o, input logic ci);
    exp_t       e;
    logic [W:0] s;
    if (!o) begin
      s   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
      e.v = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
    end else begin
      s   = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, ci};
      e.v = (x[W-1] != y[W-1]) && (s[W-1] != x[W-1]);
    end
    e.r = s[W-1:0];
    e.c = s[W];
    e.z = (e.r == '0);
    return e;
  endfunction

  // Called at a falling edge; returns at the falling edge after the accept.
  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic o, input logic ci);
    a = x; b = y; op = o; cin = ci;
    if (sel) iv4 = 1'b1; else iv1 = 1'b1;
    #1;
    chk("in_ready_at_accept", m_ir, 1);
    @(posedge clk);
    sb.push_back(model(x, y, o, ci));
    @(negedge clk);
    iv1 = 1'b0; iv4 = 1'b0;
    a = $urandom; b = $urandom; op = ~o; cin = ~ci;
  endtask

  task automatic wait_result(input int n);
    int m = 0;
    int bc = 0;
    while (!m_ov && m < n + 8) begin
      if (m_bz) bc++;
      @(negedge clk);
      m++;
    end
    chk("latency", m, n);
    chk("busy_cycles", bc, n);
    chk("busy_low_in_done", m_bz, 0);
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
    end else begin
      last_exp = sb.pop_front();
      chk("result", m_res, last_exp.r);
      chk("cout", m_co, last_exp.c);
      chk("ovf", m_vf, last_exp.v);
      chk("zero", m_z, last_exp.z);
    end
  endtask

  task automatic finish_handshake();
    @(negedge clk);
    chk("out_valid_drop", m_ov, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t prior;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_result", m_res, 0);
    chk("rst_flags", {m_co, m_vf, m_z}, 0);
    chk("rst_out_valid", m_ov, 0);
    chk("rst_busy", m_bz, 0);
    chk("rst_in_ready", m_ir, 1);
    @(negedge clk);

    sel = 1'b0;
    start_op(32'd5, 32'd3, 1'b1, 1'b0);
    wait_result(32);
    finish_handshake();
    start_op(32'd3, 32'd5, 1'b1, 1'b0);
    wait_result(32);
    finish_handshake();
    start_op(32'h8000_0000, 32'd1, 1'b1, 1'b0);
    wait_result(32);
    finish_handshake();

    // Abort when digit 10 would be processed.
    prior = last_exp;
    start_op(32'h1234_5678, 32'h0000_1111, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", m_bz, 0);
    chk("abort_out_valid", m_ov, 0);
    chk("abort_in_ready", m_ir, 1);
    chk("abort_result_held", m_res, prior.r);
    void'(sb.pop_back());
    repeat (3) @(negedge clk);
    chk("abort_no_valid_later", m_ov, 0);
    start_op(32'hCAFE_0001, 32'h0000_0F00, 1'b1, 1'b1);
    wait_result(32);
    finish_handshake();

    // Asynchronous reset at digit 16, away from any rising edge.
    start_op(32'hDEAD_BEEF, 32'h0101_0101, 1'b0, 1'b0);
    repeat (16) @(negedge clk);
    chk("busy_before_reset", m_bz, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_result", m_res, 0);
    chk("async_rst_flags", {m_co, m_vf, m_z}, 0);
    chk("async_rst_valid_busy", {m_ov, m_bz}, 0);
    void'(sb.pop_back());
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    start_op(32'd7, 32'd8, 1'b0, 1'b1);
    wait_result(32);
    finish_handshake();

    sel = 1'b1;
    start_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    wait_result(8);
    finish_handshake();
    start_op(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
    wait_result(8);
    finish_handshake();
    for (int i = 0; i < 4; i++) begin
      start_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      wait_result(8);
      finish_handshake();
    end

    // Back-pressure then back-to-back accept on the releasing edge.
    out_ready = 1'b0;
    start_op(32'h0000_00FF, 32'h0000_0100, 1'b1, 1'b0);
    wait_result(8);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid_held", m_ov, 1);
      chk("bp_result_held", m_res, last_exp.r);
      chk("bp_flags_held", {m_co, m_vf, m_z}, {last_exp.c, last_exp.v, last_exp.z});
      chk("bp_in_ready_low", m_ir, 0);
    end
    out_ready = 1'b1;
    start_op(32'h1111_2222, 32'h3333_4444, 1'b0, 1'b1);
    wait_result(8);
    finish_handshake();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
